// File: rtl/render_pkg.sv
// Shared types and constants for the byte-stream object renderer.
package render_pkg;

  localparam logic [5:0] OBJ_POINT = 6'd0;
  localparam logic [5:0] OBJ_LINE  = 6'd1;
  localparam logic [5:0] OBJ_TRI   = 6'd2;

  typedef enum logic [1:0] {
    StHdr,
    StLoad,
    StSetup,
    StDraw
  } state_e;

  // Vertex count an object type requires; 0 marks an unknown type.
  function automatic logic [1:0] req_verts(input logic [5:0] obj_type);
    case (obj_type)
      OBJ_POINT: return 2'd1;
      OBJ_LINE:  return 2'd2;
      OBJ_TRI:   return 2'd3;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/render_engine_if.sv
// Command byte stream in, pixel coordinate stream out; slave is the engine side.
interface render_engine_if #(
  parameter int unsigned COORD_W = 8
) ();

  logic               byte_valid;
  logic               byte_ready;
  logic [7:0]         rbyte;
  logic               pix_valid;
  logic               pix_ready;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;

  modport master (
    output byte_valid, rbyte, pix_ready,
    input  byte_ready, pix_valid, pix_x, pix_y
  );

  modport slave (
    input  byte_valid, rbyte, pix_ready,
    output byte_ready, pix_valid, pix_x, pix_y
  );

endinterface

// File: rtl/line_stepper.sv
// Integer Bresenham stepper: presents the current point, walks one step per advance,
// endpoint-inclusive in both directions.
module line_stepper #(
  parameter int unsigned COORD_W = 8
) (
  input  logic               ACLK,
  input  logic               ARESET,
  input  logic               load,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  input  logic               advance,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  localparam int unsigned DW  = COORD_W + 1;
  localparam int unsigned EW  = COORD_W + 2;
  localparam int unsigned E2W = COORD_W + 3;

  logic [COORD_W-1:0] x_q, y_q, xe_q, ye_q, sx_q, sy_q;
  logic signed [DW-1:0] dx_q, dy_q;
  logic signed [EW-1:0] err_q;

  logic signed [DW-1:0]  ddx, ddy, adx, ady;
  logic signed [E2W-1:0] e2;
  logic                  step_x, step_y;
  logic signed [EW-1:0]  err_step;

  always_comb begin
    ddx      = $signed({1'b0, x1}) - $signed({1'b0, x0});
    ddy      = $signed({1'b0, y1}) - $signed({1'b0, y0});
    adx      = ddx[DW-1] ? -ddx : ddx;
    ady      = ddy[DW-1] ? -ddy : ddy;
    e2       = $signed({err_q, 1'b0});
    step_x   = e2 >= E2W'(dy_q);
    step_y   = e2 <= E2W'(dx_q);
    err_step = err_q;
    if (step_x) err_step = err_step + EW'(dy_q);
    if (step_y) err_step = err_step + EW'(dx_q);
  end

  // Steps are stored as +1 / all-ones / 0 so a plain add moves the coordinate.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      x_q   <= '0;
      y_q   <= '0;
      xe_q  <= '0;
      ye_q  <= '0;
      sx_q  <= '0;
      sy_q  <= '0;
      dx_q  <= '0;
      dy_q  <= '0;
      err_q <= '0;
    end else if (load) begin
      x_q   <= x0;
      y_q   <= y0;
      xe_q  <= x1;
      ye_q  <= y1;
      dx_q  <= adx;
      dy_q  <= -ady;
      err_q <= EW'(adx) - EW'(ady);
      if (ddx == '0)      sx_q <= '0;
      else if (ddx[DW-1]) sx_q <= '1;
      else                sx_q <= COORD_W'(1);
      if (ddy == '0)      sy_q <= '0;
      else if (ddy[DW-1]) sy_q <= '1;
      else                sy_q <= COORD_W'(1);
    end else if (advance && !last) begin
      if (step_x) x_q <= x_q + sx_q;
      if (step_y) y_q <= y_q + sy_q;
      err_q <= err_step;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = (x_q == xe_q) && (y_q == ye_q);

endmodule

// File: rtl/render_engine.sv
// Parses framed point/line/triangle commands from the byte stream and emits their
// outline pixels one per cycle through the line stepper.
module render_engine
  import render_pkg::*;
#(
  parameter int unsigned COORD_W   = 8,
  parameter int unsigned MAX_VERTS = 3
) (
  input  logic            ACLK,
  input  logic            ARESET,
  render_engine_if.slave  bus,
  output logic            busy,
  output logic            finish_read,
  output logic            finish_write,
  output logic            err
);

  localparam int unsigned BPC = COORD_W / 8;

  state_e state_q, state_d;

  logic [5:0]         obj_type_q;
  logic [1:0]         nv_q;
  logic [7:0]         byte_idx_q;
  logic [2:0]         coord_idx_q;
  logic [COORD_W-1:0] vx_q [MAX_VERTS];
  logic [COORD_W-1:0] vy_q [MAX_VERTS];
  logic [1:0]         seg_q;
  logic               finish_read_q, finish_write_q, err_q;

  logic               byte_ready, pix_fire, last_byte, obj_ok, last_seg;
  logic               step_load, step_last;
  logic [1:0]         load_seg, va, vb;
  logic [COORD_W-1:0] cur_x, cur_y;

  assign pix_fire  = bus.pix_valid && bus.pix_ready;
  // Final payload byte: last byte of the Y coordinate of vertex nv-1.
  assign last_byte = (byte_idx_q == 8'(BPC - 1)) && (coord_idx_q == {nv_q - 2'd1, 1'b1});
  assign obj_ok    = (obj_type_q <= OBJ_TRI) && (nv_q == req_verts(obj_type_q));
  assign last_seg  = (obj_type_q == OBJ_TRI) ? (seg_q == 2'd2) : 1'b1;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= StHdr;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    byte_ready = 1'b0;
    step_load  = 1'b0;
    load_seg   = seg_q;
    unique case (state_q)
      StHdr: begin
        byte_ready = 1'b1;
        if (bus.byte_valid) state_d = (bus.rbyte[1:0] == 2'd0) ? StSetup : StLoad;
      end
      StLoad: begin
        byte_ready = 1'b1;
        if (bus.byte_valid && last_byte) state_d = StSetup;
      end
      StSetup: begin
        if (obj_ok) begin
          step_load = 1'b1;
          load_seg  = 2'd0;
          state_d   = StDraw;
        end else begin
          state_d = StHdr;
        end
      end
      StDraw: begin
        // Next segment loads on the same edge the previous one's last pixel leaves.
        if (pix_fire && step_last) begin
          if (last_seg) begin
            state_d = StHdr;
          end else begin
            step_load = 1'b1;
            load_seg  = seg_q + 2'd1;
          end
        end
      end
      default: state_d = StHdr;
    endcase
  end

  always_comb begin
    va = 2'd0;
    vb = 2'd1;
    case (load_seg)
      2'd0:    begin va = 2'd0; vb = (obj_type_q == OBJ_POINT) ? 2'd0 : 2'd1; end
      2'd1:    begin va = 2'd1; vb = 2'd2; end
      default: begin va = 2'd2; vb = 2'd0; end
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      obj_type_q     <= '0;
      nv_q           <= '0;
      byte_idx_q     <= '0;
      coord_idx_q    <= '0;
      seg_q          <= '0;
      finish_read_q  <= 1'b0;
      finish_write_q <= 1'b0;
      err_q          <= 1'b0;
      for (int unsigned i = 0; i < MAX_VERTS; i++) begin
        vx_q[i] <= '0;
        vy_q[i] <= '0;
      end
    end else begin
      finish_read_q  <= 1'b0;
      finish_write_q <= 1'b0;
      err_q          <= 1'b0;
      case (state_q)
        StHdr: begin
          if (bus.byte_valid) begin
            obj_type_q    <= bus.rbyte[7:2];
            nv_q          <= bus.rbyte[1:0];
            byte_idx_q    <= '0;
            coord_idx_q   <= '0;
            finish_read_q <= (bus.rbyte[1:0] == 2'd0);
          end
        end
        StLoad: begin
          if (bus.byte_valid) begin
            for (int unsigned i = 0; i < MAX_VERTS; i++) begin
              for (int unsigned b = 0; b < BPC; b++) begin
                if (coord_idx_q[2:1] == i[1:0] && byte_idx_q == b[7:0]) begin
                  if (coord_idx_q[0]) vy_q[i][8*b +: 8] <= bus.rbyte;
                  else                vx_q[i][8*b +: 8] <= bus.rbyte;
                end
              end
            end
            if (byte_idx_q == 8'(BPC - 1)) begin
              byte_idx_q  <= '0;
              coord_idx_q <= coord_idx_q + 3'd1;
            end else begin
              byte_idx_q <= byte_idx_q + 8'd1;
            end
            finish_read_q <= last_byte;
          end
        end
        StSetup: begin
          err_q <= !obj_ok;
          seg_q <= '0;
        end
        StDraw: begin
          if (step_load) seg_q <= load_seg;
          finish_write_q <= pix_fire && step_last && last_seg;
        end
        default: ;
      endcase
    end
  end

  line_stepper #(
    .COORD_W(COORD_W)
  ) u_stepper (
    .ACLK    (ACLK),
    .ARESET  (ARESET),
    .load    (step_load),
    .x0      (vx_q[va]),
    .y0      (vy_q[va]),
    .x1      (vx_q[vb]),
    .y1      (vy_q[vb]),
    .advance (pix_fire),
    .x       (cur_x),
    .y       (cur_y),
    .last    (step_last)
  );

  assign bus.byte_ready = byte_ready;
  assign bus.pix_valid  = (state_q == StDraw);
  assign bus.pix_x      = cur_x;
  assign bus.pix_y      = cur_y;
  assign busy           = (state_q != StHdr);
  assign finish_read    = finish_read_q;
  assign finish_write   = finish_write_q;
  assign err            = err_q;

endmodule

// File: tb/tb_render_engine.sv
// Scoreboard bench for render_engine: 8-bit and 16-bit coordinate instances.
module tb_render_engine;

  logic ACLK = 1'b0;
  logic rst;

  render_engine_if #(.COORD_W(8))  if8 ();
  render_engine_if #(.COORD_W(16)) if16 ();

  logic busy8, fr8, fw8, err8;
  logic busy16, fr16, fw16, err16;

  render_engine #(.COORD_W(8), .MAX_VERTS(3)) dut8 (
    .ACLK(ACLK), .ARESET(rst), .bus(if8),
    .busy(busy8), .finish_read(fr8), .finish_write(fw8), .err(err8)
  );

  render_engine #(.COORD_W(16), .MAX_VERTS(3)) dut16 (
    .ACLK(ACLK), .ARESET(rst), .bus(if16),
    .busy(busy16), .finish_read(fr16), .finish_write(fw16), .err(err16)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;
  int n_fr8 = 0, n_fw8 = 0, n_err8 = 0, n_pix8 = 0;
  int n_fw16 = 0, n_err16 = 0, n_pix16 = 0;
  logic [31:0] q8[$];
  logic [31:0] q16[$];
  logic [31:0] exp8, exp16, got8, got16;

  function automatic logic [31:0] pk(input int x, input int y);
    return {x[15:0], y[15:0]};
  endfunction

  // Pulse counters and pixel scoreboards, sampled mid-cycle.
  always @(negedge ACLK) begin
    if (fr8)   n_fr8++;
    if (fw8)   n_fw8++;
    if (err8)  n_err8++;
    if (fw16)  n_fw16++;
    if (err16) n_err16++;
    if (if8.pix_valid && if8.pix_ready) begin
      n_pix8++;
      total++;
      got8 = {16'(if8.pix_x), 16'(if8.pix_y)};
      if (q8.size() == 0) begin
        bad++;
        $display("FAIL pix8_unexpected got=(%0d,%0d) want=none", if8.pix_x, if8.pix_y);
      end else begin
        exp8 = q8.pop_front();
        if (got8 !== exp8) begin
          bad++;
          $display("FAIL pix8 got=(%0d,%0d) want=(%0d,%0d)", got8[31:16], got8[15:0],
                   exp8[31:16], exp8[15:0]);
        end
      end
    end
    if (if16.pix_valid && if16.pix_ready) begin
      n_pix16++;
      total++;
      got16 = {if16.pix_x, if16.pix_y};
      if (q16.size() == 0) begin
        bad++;
        $display("FAIL pix16_unexpected got=(%0d,%0d) want=none", if16.pix_x, if16.pix_y);
      end else begin
        exp16 = q16.pop_front();
        if (got16 !== exp16) begin
          bad++;
          $display("FAIL pix16 got=(%0d,%0d) want=(%0d,%0d)", got16[31:16], got16[15:0],
                   exp16[31:16], exp16[15:0]);
        end
      end
    end
  end

  task automatic send8(input logic [7:0] b);
    bit ok = 1'b0;
    if8.byte_valid = 1'b1;
    if8.rbyte      = b;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge ACLK);
      ok = if8.byte_ready;
      @(posedge ACLK);
      #1;
    end
    if8.byte_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send8_timeout got=byte_ready0 want=byte_ready1");
    end
  endtask

  task automatic send16(input logic [7:0] b);
    bit ok = 1'b0;
    if16.byte_valid = 1'b1;
    if16.rbyte      = b;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge ACLK);
      ok = if16.byte_ready;
      @(posedge ACLK);
      #1;
    end
    if16.byte_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send16_timeout got=byte_ready0 want=byte_ready1");
    end
  endtask

  task automatic test_reset();
    @(negedge ACLK);
    total++;
    if ({if8.byte_ready, if8.pix_valid, busy8, fr8, fw8, err8} !== 6'b100000) begin
      bad++;
      $display("FAIL reset8_ctrl got=%b want=100000",
               {if8.byte_ready, if8.pix_valid, busy8, fr8, fw8, err8});
    end
    total++;
    if ({if8.pix_x, if8.pix_y} !== 16'h0) begin
      bad++;
      $display("FAIL reset8_pix got=%h want=0000", {if8.pix_x, if8.pix_y});
    end
    total++;
    if ({if16.byte_ready, if16.pix_valid, busy16, fr16, fw16, err16} !== 6'b100000) begin
      bad++;
      $display("FAIL reset16_ctrl got=%b want=100000",
               {if16.byte_ready, if16.pix_valid, busy16, fr16, fw16, err16});
    end
    @(posedge ACLK);
    #1;
    rst = 1'b0;
    @(negedge ACLK);
    total++;
    if ({if8.byte_ready, busy8} !== 2'b10) begin
      bad++;
      $display("FAIL after_reset got=%b want=10", {if8.byte_ready, busy8});
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic test_point();
    int fr0 = n_fr8;
    int fw0 = n_fw8;
    q8.push_back(pk(5, 7));
    send8(8'h01); send8(8'h05); send8(8'h07);
    for (int i = 0; i < 40 && q8.size() != 0; i++) @(posedge ACLK);
    #1;
    repeat (2) @(posedge ACLK);
    #1;
    total++;
    if (q8.size() != 0) begin
      bad++;
      $display("FAIL point_drain got=%0d want=0", q8.size());
    end
    total++;
    if ((n_fr8 - fr0) != 1 || (n_fw8 - fw0) != 1) begin
      bad++;
      $display("FAIL point_pulses got=fr%0d,fw%0d want=fr1,fw1", n_fr8 - fr0, n_fw8 - fw0);
    end
    total++;
    if (busy8 !== 1'b0) begin
      bad++;
      $display("FAIL point_busy got=%b want=0", busy8);
    end
  endtask

  task automatic test_line();
    int bubbles = 0;
    q8.push_back(pk(0, 0)); q8.push_back(pk(1, 0));
    q8.push_back(pk(2, 1)); q8.push_back(pk(3, 1));
    send8(8'h06); send8(8'h00); send8(8'h00); send8(8'h03); send8(8'h01);
    @(negedge ACLK);
    total++;
    if ({if8.pix_valid, fr8, busy8} !== 3'b011) begin
      bad++;
      $display("FAIL line_setup got=%b want=011", {if8.pix_valid, fr8, busy8});
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge ACLK);
      if ({if8.pix_valid, if8.byte_ready} !== 2'b10) bubbles++;
    end
    total++;
    if (bubbles != 0) begin
      bad++;
      $display("FAIL line_consecutive got=%0d want=0", bubbles);
    end
    @(negedge ACLK);
    total++;
    if ({if8.pix_valid, fw8, busy8} !== 3'b010) begin
      bad++;
      $display("FAIL line_finish got=%b want=010", {if8.pix_valid, fw8, busy8});
    end
    @(posedge ACLK);
    #1;
    // Reverse direction
    q8.push_back(pk(3, 1)); q8.push_back(pk(2, 1));
    q8.push_back(pk(1, 0)); q8.push_back(pk(0, 0));
    send8(8'h06); send8(8'h03); send8(8'h01); send8(8'h00); send8(8'h00);
    for (int i = 0; i < 40 && q8.size() != 0; i++) @(posedge ACLK);
    #1;
    total++;
    if (q8.size() != 0) begin
      bad++;
      $display("FAIL line_rev_drain got=%0d want=0", q8.size());
    end
    repeat (2) @(posedge ACLK);
    #1;
  endtask

  task automatic test_triangle();
    int gaps = 0;
    int fw0  = n_fw8;
    q8.push_back(pk(0, 0)); q8.push_back(pk(1, 0)); q8.push_back(pk(2, 0));
    q8.push_back(pk(2, 0)); q8.push_back(pk(1, 1)); q8.push_back(pk(0, 2));
    q8.push_back(pk(0, 2)); q8.push_back(pk(0, 1)); q8.push_back(pk(0, 0));
    send8(8'h0B);
    send8(8'h00); send8(8'h00); send8(8'h02); send8(8'h00); send8(8'h00); send8(8'h02);
    @(negedge ACLK);
    for (int k = 0; k < 9; k++) begin
      @(negedge ACLK);
      if (!if8.pix_valid) gaps++;
    end
    total++;
    if (gaps != 0) begin
      bad++;
      $display("FAIL tri_bubbles got=%0d want=0", gaps);
    end
    @(negedge ACLK);
    total++;
    if ({if8.pix_valid, fw8} !== 2'b01) begin
      bad++;
      $display("FAIL tri_finish got=%b want=01", {if8.pix_valid, fw8});
    end
    @(posedge ACLK);
    #1;
    total++;
    if (q8.size() != 0 || (n_fw8 - fw0) != 1) begin
      bad++;
      $display("FAIL tri_done got=left%0d,fw%0d want=left0,fw1", q8.size(), n_fw8 - fw0);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0]  pat    = 4'b1001;
    logic [15:0] held   = '0;
    bit          held_v = 1'b0;
    int          fw0    = n_fw8;
    q8.push_back(pk(0, 0)); q8.push_back(pk(1, 0));
    q8.push_back(pk(2, 1)); q8.push_back(pk(3, 1));
    send8(8'h06); send8(8'h00); send8(8'h00); send8(8'h03); send8(8'h01);
    for (int k = 0; k < 60 && q8.size() != 0; k++) begin
      if8.pix_ready = pat[k % 4];
      @(negedge ACLK);
      if (if8.pix_valid) begin
        total++;
        if (if8.byte_ready !== 1'b0) begin
          bad++;
          $display("FAIL bp_byte_ready got=%b want=0", if8.byte_ready);
        end
        if (held_v) begin
          total++;
          if ({if8.pix_x, if8.pix_y} !== held) begin
            bad++;
            $display("FAIL bp_stable got=%h want=%h", {if8.pix_x, if8.pix_y}, held);
          end
        end
        if (!if8.pix_ready) begin
          held   = {if8.pix_x, if8.pix_y};
          held_v = 1'b1;
        end else begin
          held_v = 1'b0;
        end
      end
      @(posedge ACLK);
      #1;
    end
    if8.pix_ready = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    total++;
    if (q8.size() != 0 || (n_fw8 - fw0) != 1) begin
      bad++;
      $display("FAIL bp_done got=left%0d,fw%0d want=left0,fw1", q8.size(), n_fw8 - fw0);
    end
  endtask

  task automatic test_malformed();
    int fr0  = n_fr8;
    int err0 = n_err8;
    int pix0 = n_pix8;
    int fw0;
    send8(8'h05); send8(8'h01); send8(8'h02);
    repeat (4) @(posedge ACLK);
    #1;
    total++;
    if ((n_err8 - err0) != 1 || (n_fr8 - fr0) != 1 || (n_pix8 - pix0) != 0) begin
      bad++;
      $display("FAIL malformed got=err%0d,fr%0d,pix%0d want=err1,fr1,pix0",
               n_err8 - err0, n_fr8 - fr0, n_pix8 - pix0);
    end
    fw0 = n_fw8;
    q8.push_back(pk(200, 3));
    send8(8'h01); send8(8'hC8); send8(8'h03);
    for (int i = 0; i < 40 && q8.size() != 0; i++) @(posedge ACLK);
    #1;
    repeat (2) @(posedge ACLK);
    #1;
    total++;
    if (q8.size() != 0 || (n_fw8 - fw0) != 1) begin
      bad++;
      $display("FAIL after_malformed got=left%0d,fw%0d want=left0,fw1", q8.size(), n_fw8 - fw0);
    end
  endtask

  task automatic test_reset_mid_draw();
    int fw0, err0;
    q8.push_back(pk(0, 0)); q8.push_back(pk(1, 0));
    q8.push_back(pk(2, 1)); q8.push_back(pk(3, 1));
    send8(8'h06); send8(8'h00); send8(8'h00); send8(8'h03); send8(8'h01);
    for (int i = 0; i < 40 && q8.size() > 2; i++) @(posedge ACLK);
    #1;
    rst  = 1'b1;
    fw0  = n_fw8;
    err0 = n_err8;
    q8.delete();
    @(negedge ACLK);
    total++;
    if ({if8.pix_valid, busy8, if8.byte_ready, if8.pix_x, if8.pix_y} !== 19'b0010000000000000000)
    begin
      bad++;
      $display("FAIL reset_mid got=%b,%0d,%0d want=001,0,0",
               {if8.pix_valid, busy8, if8.byte_ready}, if8.pix_x, if8.pix_y);
    end
    @(posedge ACLK);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge ACLK);
    #1;
    total++;
    if ((n_fw8 - fw0) != 0 || (n_err8 - err0) != 0) begin
      bad++;
      $display("FAIL reset_mid_pulses got=fw%0d,err%0d want=fw0,err0", n_fw8 - fw0, n_err8 - err0);
    end
    q8.push_back(pk(1, 2));
    send8(8'h01); send8(8'h01); send8(8'h02);
    for (int i = 0; i < 40 && q8.size() != 0; i++) @(posedge ACLK);
    #1;
    repeat (2) @(posedge ACLK);
    #1;
    total++;
    if (q8.size() != 0 || (n_fw8 - fw0) != 1) begin
      bad++;
      $display("FAIL reset_mid_next got=left%0d,fw%0d want=left0,fw1", q8.size(), n_fw8 - fw0);
    end
  endtask

  task automatic test_wide();
    int fw0  = n_fw16;
    int pix0 = n_pix16;
    q16.push_back(pk(256, 0)); q16.push_back(pk(257, 0)); q16.push_back(pk(258, 0));
    send16(8'h06);
    send16(8'h00); send16(8'h01); send16(8'h00); send16(8'h00);
    send16(8'h02); send16(8'h01); send16(8'h00); send16(8'h00);
    for (int i = 0; i < 40 && q16.size() != 0; i++) @(posedge ACLK);
    #1;
    repeat (2) @(posedge ACLK);
    #1;
    total++;
    if (q16.size() != 0 || (n_fw16 - fw0) != 1 || (n_pix16 - pix0) != 3) begin
      bad++;
      $display("FAIL wide got=left%0d,fw%0d,pix%0d want=left0,fw1,pix3",
               q16.size(), n_fw16 - fw0, n_pix16 - pix0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    if8.byte_valid  = 1'b0;
    if8.rbyte       = 8'h00;
    if8.pix_ready   = 1'b1;
    if16.byte_valid = 1'b0;
    if16.rbyte      = 8'h00;
    if16.pix_ready  = 1'b1;
    repeat (3) @(posedge ACLK);
    #1;
    test_reset();
    test_point();
    test_line();
    test_triangle();
    test_backpressure();
    test_malformed();
    test_reset_mid_draw();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/render_engine.md
Name: render_engine

Overview:
- Parametrised successor of the byte-stream object renderer.
- Accepts a framed command stream (header byte + vertex coordinates) over a valid/ready byte interface. Rasterises points, lines and triangle outlines with an integer Bresenham stepper.
- Emits one pixel coordinate per cycle over a valid/ready pixel interface to the frame-buffer writer.
- Sits between the command FIFO reader and the pixel write path.

Parameters:
- COORD_W, 8, coordinate width in bits; must be a multiple of 8.
- BPC, COORD_W/8, bytes per coordinate (derived localparam), little-endian on the byte stream.
- MAX_VERTS, 3, vertex register depth; fixed minimum 3 for triangle support.

Ports:
- ACLK  in  1  clock; all state changes on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- byte_valid  in  1  rbyte holds a valid stream byte.
- byte_ready  out  1  engine accepts rbyte this cycle.
- rbyte  in  8  command stream byte.
- pix_valid  out  1  pix_x/pix_y hold a valid pixel.
- pix_ready  in  1  downstream accepts the pixel.
- pix_x  out  COORD_W  pixel X.
- pix_y  out  COORD_W  pixel Y.
- busy  out  1  high in any state except HDR.
- finish_read  out  1  one-cycle pulse when the last byte of an object is accepted.
- finish_write  out  1  one-cycle pulse when the last pixel of an object is accepted.
- err  out  1  one-cycle pulse on a malformed object.

Behaviour:
- Reset (async assert, sync release): state=HDR; all outputs 0 except byte_ready=1; vertex regs 0. Reset mid-object discards the object with no pulses.
- Byte transfer occurs when byte_valid&&byte_ready. Pixel transfer occurs when pix_valid&&pix_ready.
- Header byte fields:
  - type = rbyte[7:2]: 0 = point (needs 1 vertex), 1 = line (needs 2), 2 = triangle outline (needs 3).
  - nv = rbyte[1:0]: vertices following.
  - Payload = nv*2*BPC bytes, order X0,Y0,X1,Y1,X2,Y2. Each coordinate is LSB byte first.
- FSM HDR -> LOAD -> SETUP -> DRAW -> HDR:
  - HDR: byte_ready=1. Transfer latches type and nv. If nv=0, go to SETUP immediately, with finish_read pulsed the next cycle. Otherwise go to LOAD.
  - LOAD: byte_ready=1. Shifts bytes into the vertex regs. On the last payload byte, pulse finish_read (next cycle) and go to SETUP.
  - SETUP: one cycle, byte_ready=0.
    - If the type is unknown or nv != required count: pulse err, go to HDR, emit no pixels.
    - Otherwise load segment 0 into the stepper and go to DRAW.
  - DRAW: byte_ready=0. The stepper presents pixels and advances only on pixel transfer.
    - Line segments: v0->v1. Triangle segments: v0->v1, v1->v2, v2->v0.
    - After the final pixel of the final segment transfers, pulse finish_write (next cycle) and go to HDR.
- Latency: the first pix_valid asserts 2 cycles after the final payload byte transfer. The next header is accepted the cycle after finish_write.
- Stepper: each segment is inclusive of both endpoints and emits max(|dx|,|dy|)+1 pixels. Shared triangle vertices are emitted twice; no dedup.
- Stepper sustains 1 pixel/cycle under continuous pix_ready. Segment handover has 0 bubble cycles.
- Arithmetic:
  - dx, dy are signed COORD_W+1.
  - Error term is signed COORD_W+2.
  - Step direction is from sign(dx) and sign(dy).
  - Coordinates never wrap: endpoints are full-range and the path stays within the bounding box, including 0 and 2^COORD_W-1.
- Point: a single pixel (v0), then finish_write.
- pix_valid stays high and pix_x/pix_y stay stable while pix_ready=0.
- nv=3 with type=1 is malformed: all bytes are consumed, then err.

Decomposition:
- Package render_pkg holds:
  - object-type constants (OBJ_POINT=0, OBJ_LINE=1, OBJ_TRI=2);
  - FSM state enum;
  - function req_verts(type).
- Sub-module line_stepper(COORD_W):
  - inputs: load, x0/y0/x1/y1, advance;
  - outputs: x, y, last.
- render_engine holds the FSM, byte assembly, vertex regs and segment sequencing.

Test Plan:
- Point: bytes 0x01,0x05,0x07, pix_ready=1 -> one pixel (5,7); finish_read and finish_write each pulse once; busy back to 0.
- Line, COORD_W=8: 0x06,0,0,3,1 -> pixels (0,0),(1,0),(2,1),(3,1) on consecutive cycles, first 2 cycles after the last byte. Reverse line 3,1->0,0 -> 4 pixels ending at (0,0).
- Triangle: 0x0B, v=(0,0),(2,0),(0,2) -> 9 pixels in segment order, no bubbles; finish_write after the 9th transfer.
- Backpressure: toggle pix_ready 1-0-0-1 on the line above -> pixels held stable while stalled; same 4-pixel sequence; byte_ready=0 throughout DRAW.
- Malformed: 0x05 (line, nv=1) + 2 bytes -> bytes consumed, err pulse, zero pixels. A following valid point object renders normally.
- Reset mid-DRAW at pixel 2, then COORD_W=16 line 0x06, 0x00,0x01,0,0,0x02,0x01,0,0 -> no pulses from the aborted object. Line (256,0)->(258,0) emits 3 pixels.
